// File: rtl/softmax_pkg.sv
// Shared constants and pointer helper for the softmax datapath blocks.
package softmax_pkg;

  localparam int DW_DEFAULT      = 32;
  localparam int VEC_LEN_DEFAULT = 8;
  localparam int BUF_DEPTH       = 3;

  typedef logic [1:0] ptr_t;

  // Pointers step 0 -> 1 -> 2 -> 0; index 3 is never used.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_reader.sv
// Pulls words from a registered-output FIFO into a 3-entry skid queue and streams them as vectors.
// Optional FIFO_READER_STATS_EN adds beat_cnt / vec_cnt transfer counters.
module fifo_reader
  import softmax_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int VEC_LEN = VEC_LEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  input  logic          clear,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]   beat_cnt,
  output logic [31:0]   vec_cnt
`endif
);

  localparam int CW = $clog2(VEC_LEN);

  logic [DW-1:0] mem [BUF_DEPTH];
  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic [1:0]    occ;
  logic          inflight;
  logic [CW-1:0] elem_cnt;
  logic [2:0]    level;
  logic          push;
  logic          pop;
  logic          elem_wrap;

  // Reads are only issued when the queue can absorb every word already requested.
  assign level      = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && !clear && (level < 3'(BUF_DEPTH));

  assign m_valid   = (occ != 2'd0);
  assign m_data    = mem[rd_ptr];
  assign elem_wrap = (elem_cnt == CW'(VEC_LEN - 1));
  assign m_last    = m_valid && elem_wrap;

  assign push = inflight && !clear && !rst;
  assign pop  = m_valid && m_ready && !clear && !rst;

  // NOTE: storage has no reset; occ alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ      <= 2'd0;
      wr_ptr   <= ptr_t'(0);
      rd_ptr   <= ptr_t'(0);
      inflight <= 1'b0;
      elem_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) begin
        rd_ptr   <= ptr_next(rd_ptr);
        elem_cnt <= elem_wrap ? '0 : elem_cnt + CW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Counters survive clear so software can read totals across flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 32'd0;
      vec_cnt  <= 32'd0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (m_last) vec_cnt <= vec_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: upstream FIFO model plus a timestamped word scoreboard.
module tb_fifo_reader;

  localparam int DW      = 32;
  localparam int VEC_LEN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          clear;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]   beat_cnt;
  logic [31:0]   vec_cnt;
`endif

  fifo_reader #(.DW(DW), .VEC_LEN(VEC_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .clear      (clear),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef FIFO_READER_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .vec_cnt    (vec_cnt)
`endif
  );

  always #5 clk = ~clk;

  // A word the DUT has read, and the first cycle it may appear on m_data.
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] src_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            xfer_idx = 0;
  int            beat_exp = 0;
  int            vec_exp  = 0;
  logic          stall    = 1'b0;

  logic          s_valid, s_last, s_rd, s_xfer;
  logic [DW-1:0] s_data;
  int            s_cyc;

  function automatic void update_empty();
    fifo_empty = stall || (src_q.size() == 0);
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    src_q.push_back(w);
    update_empty();
  endtask

  // One clock: sample at negedge, score against the model, advance at posedge.
  task automatic cycle();
    logic          exp_valid, exp_last, exp_rd;
    logic [DW-1:0] word;
    ent_t          e;
    @(negedge clk);
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_rd    = fifo_rd_en;
    s_cyc   = cyc;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    exp_last  = exp_valid && (xfer_idx == VEC_LEN - 1);
    exp_rd    = !rst && !fifo_empty && !clear && (exp_q.size() < 3);
    checks++;
    if (s_valid !== exp_valid) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, s_valid, exp_valid);
    end
    checks++;
    if (s_last !== exp_last) begin
      failures++;
      $display("FAIL m_last cyc=%0d got=%b exp=%b", cyc, s_last, exp_last);
    end
    checks++;
    if (s_rd !== exp_rd) begin
      failures++;
      $display("FAIL fifo_rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, exp_rd);
    end
    if (exp_valid) begin
      checks++;
      if (s_data !== exp_q[0].data) begin
        failures++;
        $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, s_data, exp_q[0].data);
      end
    end
    @(posedge clk);
    s_xfer = exp_valid && m_ready && !clear && !rst;
    word   = fifo_data;
    if (s_rd && src_q.size() > 0) word = src_q.pop_front();
    if (rst || clear) begin
      exp_q.delete();
      xfer_idx = 0;
    end else begin
      if (s_xfer) begin
        e = exp_q.pop_front();
        beat_exp++;
        if (exp_last) vec_exp++;
        xfer_idx = (xfer_idx + 1) % VEC_LEN;
      end
      if (s_rd) begin
        e.data  = word;
        e.avail = cyc + 2;
        exp_q.push_back(e);
      end
    end
    if (rst) begin
      beat_exp = 0;
      vec_exp  = 0;
    end
    cyc++;
    #1;
    if (s_rd) fifo_data = word;
    update_empty();
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    clear   = 1'b0;
    stall   = 1'b0;
    update_empty();
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < 300) begin
      cycle();
      n++;
    end
    checks++;
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout src=%0d pending=%0d exp=0/0", src_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push_word(32'h55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b last=%b rd=%b exp=0/0/0", m_valid, m_last, fifo_rd_en);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (beat_cnt !== 32'd0 || vec_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats beat=%0d vec=%0d exp=0/0", beat_cnt, vec_cnt);
    end
`endif
    src_q.delete();
    update_empty();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] d [8];
    logic          l [8];
    int            c [8];
    int            got = 0;
    int            first_rd = -1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    m_ready = 1'b1;
    for (int n = 0; n < 40 && got < 8; n++) begin
      cycle();
      if (s_rd && first_rd < 0) first_rd = s_cyc;
      if (s_valid) begin
        d[got] = s_data;
        l[got] = s_last;
        c[got] = s_cyc;
        got++;
      end
    end
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=8", got);
    end else begin
      checks++;
      if (c[0] - first_rd != 2) begin
        failures++;
        $display("FAIL stream_latency got=%0d exp=2", c[0] - first_rd);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (d[i] !== DW'(i + 1) || l[i] !== (i == 7) || c[i] != c[0] + i) begin
          failures++;
          $display("FAIL stream_word%0d data=%0d last=%b cyc=%0d exp=%0d/%b/%0d",
                   i, d[i], l[i], c[i], i + 1, (i == 7), c[0] + i);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n_rd = 0;
    int got  = 0;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    repeat (10) begin
      cycle();
      if (s_rd) n_rd++;
    end
    checks++;
    if (n_rd != 3) begin
      failures++;
      $display("FAIL bp_reads got=%0d exp=3", n_rd);
    end
    checks++;
    if (s_valid !== 1'b1 || s_data !== DW'(1)) begin
      failures++;
      $display("FAIL bp_hold valid=%b data=%0d exp=1/1", s_valid, s_data);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 30 && got < 5; n++) begin
      cycle();
      if (s_xfer) got++;
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL bp_release got=%0d exp=5", got);
    end
    drain();
  endtask

  task automatic test_empty();
    int n_rd = 0;
    int n_v  = 0;
    m_ready = 1'b1;
    stall   = 1'b1;
    for (int i = 0; i < 3; i++) push_word(DW'(32'hE0 + i));
    repeat (10) begin
      cycle();
      if (s_rd) n_rd++;
      if (s_valid) n_v++;
    end
    checks++;
    if (n_rd != 0 || n_v != 0) begin
      failures++;
      $display("FAIL empty_idle reads=%0d valids=%0d exp=0/0", n_rd, n_v);
    end
    drain();
  endtask

  task automatic test_clear();
    int got = 0;
    int last_at = -1;
    logic [DW-1:0] first_d = '0;
    m_ready = 1'b0;
    for (int i = 10; i <= 20; i++) push_word(DW'(i));
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (s_rd) break;
    end
    checks++;
    if (s_rd !== 1'b1) begin
      failures++;
      $display("FAIL clear_no_read got=%b exp=1", s_rd);
    end
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_pre_valid got=%b exp=1", s_valid);
    end
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_post_valid got=%b exp=0", s_valid);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 40 && got < 8; n++) begin
      cycle();
      if (s_xfer) begin
        if (got == 0) first_d = s_data;
        if (s_last && last_at < 0) last_at = got;
        got++;
      end
    end
    checks++;
    if (got != 8 || last_at != 7 || first_d !== DW'(13)) begin
      failures++;
      $display("FAIL clear_restart count=%0d last_at=%0d first=%0d exp=8/7/13", got, last_at, first_d);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int got = 0;
    int last_at = -1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    for (int n = 0; n < 30 && got < 4; n++) begin
      cycle();
      if (s_xfer) got++;
    end
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_last !== 1'b0 || s_rd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs valid=%b last=%b rd=%b exp=0/0/0", s_valid, s_last, s_rd);
    end
    rst = 1'b0;
    for (int i = 201; i <= 208; i++) push_word(DW'(i));
    got = 0;
    for (int n = 0; n < 40 && got < 8; n++) begin
      cycle();
      if (s_xfer) begin
        if (s_last && last_at < 0) last_at = got;
        got++;
      end
    end
    checks++;
    if (got != 8 || last_at != 7) begin
      failures++;
      $display("FAIL midreset_last count=%0d last_at=%0d exp=8/7", got, last_at);
    end
    drain();
  endtask

  task automatic test_stats();
    int n_x = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom));
    for (int n = 0; n < 80 && n_x < 16; n++) begin
      cycle();
      if (s_xfer) n_x++;
    end
    checks++;
    if (n_x != 16) begin
      failures++;
      $display("FAIL stats_xfers got=%0d exp=16", n_x);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (beat_cnt !== 32'd16 || vec_cnt !== 32'd2) begin
      failures++;
      $display("FAIL stats_counts beat=%0d vec=%0d exp=16/2", beat_cnt, vec_cnt);
    end
`endif
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      m_ready = ($urandom_range(3) != 0);
      stall   = ($urandom_range(4) == 0);
      clear   = ($urandom_range(39) == 0);
      if ($urandom_range(1) == 1 && src_q.size() < 20) src_q.push_back(DW'($urandom));
      update_empty();
      cycle();
    end
    drain();
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (beat_cnt !== 32'(beat_exp) || vec_cnt !== 32'(vec_exp)) begin
      failures++;
      $display("FAIL random_stats beat=%0d vec=%0d exp=%0d/%0d", beat_cnt, vec_cnt, beat_exp, vec_exp);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    m_ready    = 1'b0;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty();
    test_clear();
    test_reset_mid();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
